ddr3_req_sequencer: RTL and testbench
=====================================

Name: ddr3_req_sequencer

Overview:
- Upstream feeder for the DDR3 MIG wrapper: turns client write and read requests into MIG app-interface commands.
- Accepts independent write and read request streams over valid/ready and arbitrates round-robin between them.
- Drives app_en/app_cmd/app_addr and the write-data path under the app_rdy/app_wdf_rdy handshake, tracks outstanding reads and returns read data to the client.
- Sits in the ui_clk domain; clk is the MIG ui_clk and rst is the MIG ui_clk_sync_rst.

Parameters:
- ADDR_W, 30, app address width
- DATA_W, 512, app data width
- MASK_W, 64, byte-mask width (DATA_W/8)
- MAX_OUTST, 16, maximum reads in flight
- CNT_W, 5, outstanding-counter width (must hold MAX_OUTST)

Ports:
- clk  in  1  MIG ui_clk; the only clock
- rst  in  1  asynchronous, active-high reset
- init_calib_complete  in  1  MIG calibration done
- wr_req_valid  in  1  write request present
- wr_req_ready  out  1  write request accepted this cycle
- wr_req_addr  in  ADDR_W  write address
- wr_req_data  in  DATA_W  write data
- wr_req_mask  in  MASK_W  byte disable, active-high (MIG polarity)
- rd_req_valid  in  1  read request present
- rd_req_ready  out  1  read request accepted this cycle
- rd_req_addr  in  ADDR_W  read address
- rd_rsp_valid  out  1  read data valid; one-cycle pulse, no backpressure
- rd_rsp_data  out  DATA_W  read data
- app_addr  out  ADDR_W  to MIG
- app_cmd  out  3  3'b000 write, 3'b001 read
- app_en  out  1  command valid
- app_rdy  in  1  command accepted when app_en high
- app_wdf_data  out  DATA_W  write data
- app_wdf_mask  out  MASK_W  write mask
- app_wdf_wren  out  1  write data valid
- app_wdf_end  out  1  last beat; always equals app_wdf_wren (one beat per burst)
- app_wdf_rdy  in  1  write data accepted when wren high
- app_rd_data  in  DATA_W  MIG read data
- app_rd_data_valid  in  1  MIG read data valid
- app_rd_data_end  in  1  MIG read data last beat
- rd_outstanding  out  CNT_W  reads issued but not yet returned
- err_underflow  out  1  sticky; cleared only by rst

Behaviour:
- Reset values: all outputs 0 (app_cmd 3'b000, app_addr 0, all data 0). State IDLE, round-robin pointer favours write.
- FSM states: IDLE, ARB, WR_ISSUE, RD_ISSUE.
- IDLE -> ARB when init_calib_complete=1.
- ARB:
  - Candidates are wr_req_valid and rd_req_valid gated by rd_outstanding<MAX_OUTST.
  - One candidate: it is granted. Both: the one not granted last time is granted.
  - The grant drives the matching *_ready high combinationally in the same cycle.
  - The request is captured into the app_* registers. Next state is WR_ISSUE or RD_ISSUE. The pointer updates.
  - With no candidate, stay in ARB.
  - If init_calib_complete=0 in ARB, go to IDLE with no grant.
- Latency: request accepted in cycle N; app_en (and app_wdf_wren for writes) high in cycle N+1.
- WR_ISSUE:
  - app_en and app_wdf_wren (with app_wdf_end) assert together, each with its own done flag.
  - app_en drops in the cycle after app_en&&app_rdy. app_wdf_wren/end drop in the cycle after wren&&app_wdf_rdy.
  - Either may complete first or both in the same cycle.
  - Exit to ARB on the cycle both flags are set; no bubble cycle is required.
  - Outputs hold stable while waiting.
- RD_ISSUE: app_en high with app_cmd=001 until app_rdy; then go to ARB. On that accept, rd_outstanding increments.
- Read return:
  - When app_rd_data_valid&&app_rd_data_end, register app_rd_data into rd_rsp_data and pulse rd_rsp_valid on the next cycle.
  - rd_outstanding decrements.
  - Increment and decrement in the same cycle leave the count unchanged.
  - A return while rd_outstanding=0 sets err_underflow and leaves the count at 0. The data is still forwarded.
- init_calib_complete falling mid-issue: the current command completes, then ARB sends the FSM to IDLE. Returns continue to be forwarded in every state.
- rst asserted mid-operation: immediate return to reset values. Any in-flight command or returns are dropped, and the counter clears.
- Read gating: at rd_outstanding=MAX_OUTST, rd_req_ready stays 0; writes proceed.

Test Plan:
- Reset, then calib=1, single write addr 0x100 data 0xA5..A5 mask 0, app_rdy=app_wdf_rdy=1 -> wr_req_ready at N; app_en/wren/end high at N+1 only; app_cmd=000, addr 0x100.
- Write with app_rdy held 0 for 3 cycles and app_wdf_rdy=1 -> wren drops after 1 cycle; app_en held 4 cycles; FSM returns to ARB once both are done; next request is not granted before that.
- Both valids high continuously for 6 grants -> grants alternate W,R,W,R,W,R; rd_outstanding reaches 3 when no data returns.
- 16 reads issued, no return -> rd_req_ready stays 0 on the 17th; a write still issues. Then one app_rd_data_valid/end with data 0x5A.. -> rd_rsp_valid one cycle later with 0x5A..; count 15; 17th read then granted.
- Read accept and a return in the same cycle -> count unchanged. A return at count 0 -> err_underflow=1, stays set until rst.
- rst pulsed while in WR_ISSUE with app_rdy=0 -> app_en/wren go 0 immediately, count 0. With calib=0 after reset, no ready is asserted despite valids.

Source files
------------

// File: rtl/ddr3_req_sequencer.sv
// ddr3_req_sequencer: round-robin feeder that turns client write/read requests into
// MIG app-interface commands, tracks outstanding reads and forwards read returns.
//
// state    | meaning
// ---------+----------------------------------------------------
// IDLE     | waiting for init_calib_complete
// ARB      | choosing the next request (round-robin write/read)
// WR_ISSUE | write command and its single data beat in flight
// RD_ISSUE | read command in flight until app_rdy
module ddr3_req_sequencer #(
    parameter int ADDR_W    = 30,
    parameter int DATA_W    = 512,
    parameter int MASK_W    = 64,
    parameter int MAX_OUTST = 16,
    parameter int CNT_W     = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_calib_complete,
    input  logic              wr_req_valid,
    output logic              wr_req_ready,
    input  logic [ADDR_W-1:0] wr_req_addr,
    input  logic [DATA_W-1:0] wr_req_data,
    input  logic [MASK_W-1:0] wr_req_mask,
    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    input  logic [ADDR_W-1:0] rd_req_addr,
    output logic              rd_rsp_valid,
    output logic [DATA_W-1:0] rd_rsp_data,
    output logic [ADDR_W-1:0] app_addr,
    output logic [2:0]        app_cmd,
    output logic              app_en,
    input  logic              app_rdy,
    output logic [DATA_W-1:0] app_wdf_data,
    output logic [MASK_W-1:0] app_wdf_mask,
    output logic              app_wdf_wren,
    output logic              app_wdf_end,
    input  logic              app_wdf_rdy,
    input  logic [DATA_W-1:0] app_rd_data,
    input  logic              app_rd_data_valid,
    input  logic              app_rd_data_end,
    output logic [CNT_W-1:0]  rd_outstanding,
    output logic              err_underflow
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ARB      = 2'd1,
        S_WR_ISSUE = 2'd2,
        S_RD_ISSUE = 2'd3
    } state_t;

    localparam logic [2:0]       CMD_WR    = 3'b000;
    localparam logic [2:0]       CMD_RD    = 3'b001;
    localparam logic [CNT_W-1:0] OUTST_MAX = CNT_W'(MAX_OUTST);

    state_t              state_q, state_d;
    logic                last_wr_q, last_wr_d;
    logic                grant_wr, grant_rd;
    logic                wr_cand, rd_cand;
    logic                cmd_done, data_done;
    logic                rd_accept, rd_return;

    logic                app_en_q, app_en_d;
    logic                wren_q, wren_d;
    logic [ADDR_W-1:0]   app_addr_q, app_addr_d;
    logic [2:0]          app_cmd_q, app_cmd_d;
    logic [DATA_W-1:0]   wdf_data_q, wdf_data_d;
    logic [MASK_W-1:0]   wdf_mask_q, wdf_mask_d;
    logic [CNT_W-1:0]    outst_q, outst_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                err_q, err_d;

    assign wr_cand   = wr_req_valid;
    assign rd_cand   = rd_req_valid && (outst_q < OUTST_MAX);
    // A handshake side is done once its valid has dropped or is being accepted now.
    assign cmd_done  = !app_en_q || app_rdy;
    assign data_done = !wren_q || app_wdf_rdy;
    assign rd_accept = (state_q == S_RD_ISSUE) && app_en_q && app_rdy;
    assign rd_return = app_rd_data_valid && app_rd_data_end;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            last_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_wr_q <= last_wr_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        last_wr_d = last_wr_q;
        case (state_q)
            S_IDLE: begin
                if (init_calib_complete) state_d = S_ARB;
            end
            S_ARB: begin
                if (!init_calib_complete) begin
                    state_d = S_IDLE;
                end else if (grant_wr) begin
                    state_d   = S_WR_ISSUE;
                    last_wr_d = 1'b1;
                end else if (grant_rd) begin
                    state_d   = S_RD_ISSUE;
                    last_wr_d = 1'b0;
                end
            end
            S_WR_ISSUE: begin
                if (cmd_done && data_done) state_d = S_ARB;
            end
            S_RD_ISSUE: begin
                if (app_rdy) state_d = S_ARB;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: arbitration, ready strobes and the app-side register updates
    always_comb begin
        grant_wr   = 1'b0;
        grant_rd   = 1'b0;
        app_en_d   = app_en_q;
        wren_d     = wren_q;
        app_addr_d = app_addr_q;
        app_cmd_d  = app_cmd_q;
        wdf_data_d = wdf_data_q;
        wdf_mask_d = wdf_mask_q;

        if (state_q == S_ARB && init_calib_complete) begin
            if (wr_cand && rd_cand) begin
                grant_wr = !last_wr_q;
                grant_rd = last_wr_q;
            end else begin
                grant_wr = wr_cand;
                grant_rd = rd_cand;
            end
        end

        if (grant_wr) begin
            app_en_d   = 1'b1;
            wren_d     = 1'b1;
            app_addr_d = wr_req_addr;
            app_cmd_d  = CMD_WR;
            wdf_data_d = wr_req_data;
            wdf_mask_d = wr_req_mask;
        end else if (grant_rd) begin
            app_en_d   = 1'b1;
            app_addr_d = rd_req_addr;
            app_cmd_d  = CMD_RD;
        end else begin
            if (app_en_q && app_rdy)   app_en_d = 1'b0;
            if (wren_q && app_wdf_rdy) wren_d   = 1'b0;
        end

        wr_req_ready = grant_wr;
        rd_req_ready = grant_rd;
    end

    // Outstanding-read count and read return path
    always_comb begin
        outst_d     = outst_q;
        err_d       = err_q;
        rsp_valid_d = rd_return;
        rsp_data_d  = rd_return ? app_rd_data : rsp_data_q;
        if (rd_accept && !rd_return) begin
            outst_d = outst_q + 1'b1;
        end else if (rd_return && !rd_accept) begin
            if (outst_q == '0) err_d = 1'b1;
            else               outst_d = outst_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            app_en_q    <= 1'b0;
            wren_q      <= 1'b0;
            app_addr_q  <= '0;
            app_cmd_q   <= CMD_WR;
            wdf_data_q  <= '0;
            wdf_mask_q  <= '0;
            outst_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            app_en_q    <= app_en_d;
            wren_q      <= wren_d;
            app_addr_q  <= app_addr_d;
            app_cmd_q   <= app_cmd_d;
            wdf_data_q  <= wdf_data_d;
            wdf_mask_q  <= wdf_mask_d;
            outst_q     <= outst_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            err_q       <= err_d;
        end
    end

    assign app_en         = app_en_q;
    assign app_cmd        = app_cmd_q;
    assign app_addr       = app_addr_q;
    assign app_wdf_data   = wdf_data_q;
    assign app_wdf_mask   = wdf_mask_q;
    assign app_wdf_wren   = wren_q;
    assign app_wdf_end    = wren_q;
    assign rd_outstanding = outst_q;
    assign rd_rsp_valid   = rsp_valid_q;
    assign rd_rsp_data    = rsp_data_q;
    assign err_underflow  = err_q;

endmodule

// File: tb/tb_ddr3_req_sequencer.sv
// Directed bench for ddr3_req_sequencer: a vector table for arbitration and
// issue timing, then hand-written sequences for stalls, read gating, returns and reset.
module tb_ddr3_req_sequencer;

    logic          clk = 1'b0;
    logic          rst;
    logic          init_calib_complete;
    logic          wr_req_valid;
    logic          wr_req_ready;
    logic [29:0]   wr_req_addr;
    logic [511:0]  wr_req_data;
    logic [63:0]   wr_req_mask;
    logic          rd_req_valid;
    logic          rd_req_ready;
    logic [29:0]   rd_req_addr;
    logic          rd_rsp_valid;
    logic [511:0]  rd_rsp_data;
    logic [29:0]   app_addr;
    logic [2:0]    app_cmd;
    logic          app_en;
    logic          app_rdy;
    logic [511:0]  app_wdf_data;
    logic [63:0]   app_wdf_mask;
    logic          app_wdf_wren;
    logic          app_wdf_end;
    logic          app_wdf_rdy;
    logic [511:0]  app_rd_data;
    logic          app_rd_data_valid;
    logic          app_rd_data_end;
    logic [4:0]    rd_outstanding;
    logic          err_underflow;

    int checks   = 0;
    int failures = 0;

    ddr3_req_sequencer dut (
        .clk                 (clk),
        .rst                 (rst),
        .init_calib_complete (init_calib_complete),
        .wr_req_valid        (wr_req_valid),
        .wr_req_ready        (wr_req_ready),
        .wr_req_addr         (wr_req_addr),
        .wr_req_data         (wr_req_data),
        .wr_req_mask         (wr_req_mask),
        .rd_req_valid        (rd_req_valid),
        .rd_req_ready        (rd_req_ready),
        .rd_req_addr         (rd_req_addr),
        .rd_rsp_valid        (rd_rsp_valid),
        .rd_rsp_data         (rd_rsp_data),
        .app_addr            (app_addr),
        .app_cmd             (app_cmd),
        .app_en              (app_en),
        .app_rdy             (app_rdy),
        .app_wdf_data        (app_wdf_data),
        .app_wdf_mask        (app_wdf_mask),
        .app_wdf_wren        (app_wdf_wren),
        .app_wdf_end         (app_wdf_end),
        .app_wdf_rdy         (app_wdf_rdy),
        .app_rd_data         (app_rd_data),
        .app_rd_data_valid   (app_rd_data_valid),
        .app_rd_data_end     (app_rd_data_end),
        .rd_outstanding      (rd_outstanding),
        .err_underflow       (err_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       calib, wv, rv, ardy, wdf, ret;
        logic       e_wr, e_rd, e_en;
        logic [2:0] e_cmd;
        logic       e_wren;
        logic [4:0] e_outst;
        logic       e_rsp;
    } vec_t;

    vec_t vecs [19];

    function automatic vec_t mk(input logic calib, wv, rv, ardy, wdf, ret,
                                input logic e_wr, e_rd, e_en, input logic [2:0] e_cmd,
                                input logic e_wren, input logic [4:0] e_outst, input logic e_rsp);
        vec_t v;
        v.calib = calib; v.wv = wv; v.rv = rv; v.ardy = ardy; v.wdf = wdf; v.ret = ret;
        v.e_wr = e_wr; v.e_rd = e_rd; v.e_en = e_en; v.e_cmd = e_cmd;
        v.e_wren = e_wren; v.e_outst = e_outst; v.e_rsp = e_rsp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        init_calib_complete = 1'b0;
        wr_req_valid = 1'b0; wr_req_addr = '0; wr_req_data = '0; wr_req_mask = '0;
        rd_req_valid = 1'b0; rd_req_addr = '0;
        app_rdy = 1'b0; app_wdf_rdy = 1'b0;
        app_rd_data = '0; app_rd_data_valid = 1'b0; app_rd_data_end = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // calib, wv, rv, ardy, wdf, ret | wr_rdy, rd_rdy, en, cmd, wren, outst, rsp
        vecs[0]  = mk(0,1,1,1,1,0, 0,0,0,3'b000,0,5'd0,0);
        vecs[1]  = mk(0,1,1,1,1,0, 0,0,0,3'b000,0,5'd0,0);
        vecs[2]  = mk(1,1,1,1,1,0, 0,0,0,3'b000,0,5'd0,0);
        vecs[3]  = mk(1,1,1,1,1,0, 1,0,0,3'b000,0,5'd0,0);
        vecs[4]  = mk(1,1,1,1,1,0, 0,0,1,3'b000,1,5'd0,0);
        vecs[5]  = mk(1,1,1,1,1,0, 0,1,0,3'b000,0,5'd0,0);
        vecs[6]  = mk(1,1,1,1,1,0, 0,0,1,3'b001,0,5'd0,0);
        vecs[7]  = mk(1,1,1,1,1,0, 1,0,0,3'b001,0,5'd1,0);
        vecs[8]  = mk(1,1,1,1,1,0, 0,0,1,3'b000,1,5'd1,0);
        vecs[9]  = mk(1,1,1,1,1,0, 0,1,0,3'b000,0,5'd1,0);
        vecs[10] = mk(1,1,1,1,1,0, 0,0,1,3'b001,0,5'd1,0);
        vecs[11] = mk(1,1,1,1,1,0, 1,0,0,3'b001,0,5'd2,0);
        vecs[12] = mk(1,1,1,1,1,0, 0,0,1,3'b000,1,5'd2,0);
        vecs[13] = mk(1,1,1,1,1,0, 0,1,0,3'b000,0,5'd2,0);
        vecs[14] = mk(1,1,1,1,1,0, 0,0,1,3'b001,0,5'd2,0);
        vecs[15] = mk(1,0,0,1,1,0, 0,0,0,3'b001,0,5'd3,0);
        vecs[16] = mk(1,0,0,1,1,1, 0,0,0,3'b001,0,5'd3,0);
        vecs[17] = mk(1,0,0,1,1,0, 0,0,0,3'b001,0,5'd2,1);
        vecs[18] = mk(1,0,0,1,1,0, 0,0,0,3'b001,0,5'd2,0);

        // Reset state
        do_reset();
        #1;
        chk("rst app_en", app_en, 0);
        chk("rst app_cmd", app_cmd, 0);
        chk("rst app_addr", app_addr, 0);
        chk("rst wren", app_wdf_wren, 0);
        chk("rst wdf_end", app_wdf_end, 0);
        chk("rst wdf_data", app_wdf_data, 0);
        chk("rst rsp_valid", rd_rsp_valid, 0);
        chk("rst rsp_data", rd_rsp_data, 0);
        chk("rst outstanding", rd_outstanding, 0);
        chk("rst err", err_underflow, 0);

        // Table: calibration gating and round-robin W,R,W,R,W,R with one return
        wr_req_addr = 30'h100; wr_req_data = {64{8'h11}};
        rd_req_addr = 30'h200; app_rd_data = {64{8'h3C}};
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            init_calib_complete = vecs[i].calib;
            wr_req_valid        = vecs[i].wv;
            rd_req_valid        = vecs[i].rv;
            app_rdy             = vecs[i].ardy;
            app_wdf_rdy         = vecs[i].wdf;
            app_rd_data_valid   = vecs[i].ret;
            app_rd_data_end     = vecs[i].ret;
            #1;
            chk($sformatf("vec%0d wr_ready", i), wr_req_ready, vecs[i].e_wr);
            chk($sformatf("vec%0d rd_ready", i), rd_req_ready, vecs[i].e_rd);
            chk($sformatf("vec%0d app_en", i), app_en, vecs[i].e_en);
            chk($sformatf("vec%0d app_cmd", i), app_cmd, vecs[i].e_cmd);
            chk($sformatf("vec%0d wren", i), app_wdf_wren, vecs[i].e_wren);
            chk($sformatf("vec%0d wdf_end", i), app_wdf_end, vecs[i].e_wren);
            chk($sformatf("vec%0d outstanding", i), rd_outstanding, vecs[i].e_outst);
            chk($sformatf("vec%0d rsp_valid", i), rd_rsp_valid, vecs[i].e_rsp);
        end
        chk("table rsp_data", rd_rsp_data, {64{8'h3C}});

        // Single write: ready at N, command/data at N+1 only
        do_reset();
        @(negedge clk);
        init_calib_complete = 1'b1; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        @(negedge clk);
        wr_req_valid = 1'b1; wr_req_addr = 30'h100;
        wr_req_data = {64{8'hA5}}; wr_req_mask = '0;
        #1;
        chk("w1 wr_ready N", wr_req_ready, 1);
        chk("w1 app_en N", app_en, 0);
        @(negedge clk);
        wr_req_valid = 1'b0;
        #1;
        chk("w1 wr_ready N+1", wr_req_ready, 0);
        chk("w1 app_en N+1", app_en, 1);
        chk("w1 wren N+1", app_wdf_wren, 1);
        chk("w1 wdf_end N+1", app_wdf_end, 1);
        chk("w1 app_cmd", app_cmd, 3'b000);
        chk("w1 app_addr", app_addr, 30'h100);
        chk("w1 wdf_data", app_wdf_data, {64{8'hA5}});
        chk("w1 wdf_mask", app_wdf_mask, 0);
        @(negedge clk);
        #1;
        chk("w1 app_en N+2", app_en, 0);
        chk("w1 wren N+2", app_wdf_wren, 0);
        chk("w1 wdf_end N+2", app_wdf_end, 0);

        // Write with app_rdy stalled 3 cycles; next write must wait for both done
        @(negedge clk);
        wr_req_valid = 1'b1; wr_req_addr = 30'h140; app_rdy = 1'b0; app_wdf_rdy = 1'b1;
        #1;
        chk("w2 wr_ready N", wr_req_ready, 1);
        @(negedge clk);
        wr_req_addr = 30'h180;
        #1;
        chk("w2 app_en N+1", app_en, 1);
        chk("w2 wren N+1", app_wdf_wren, 1);
        chk("w2 wr_ready N+1", wr_req_ready, 0);
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk);
            if (k == 4) app_rdy = 1'b1;
            #1;
            chk($sformatf("w2 app_en N+%0d", k), app_en, 1);
            chk($sformatf("w2 wren N+%0d", k), app_wdf_wren, 0);
            chk($sformatf("w2 wr_ready N+%0d", k), wr_req_ready, 0);
            chk($sformatf("w2 addr N+%0d", k), app_addr, 30'h140);
        end
        @(negedge clk);
        #1;
        chk("w2 app_en N+5", app_en, 0);
        chk("w2 wr_ready N+5", wr_req_ready, 1);
        @(negedge clk);
        wr_req_valid = 1'b0;
        #1;
        chk("w3 app_en", app_en, 1);
        chk("w3 app_addr", app_addr, 30'h180);

        // Sixteen reads with no return, then gating, a write, and a return
        do_reset();
        @(negedge clk);
        init_calib_complete = 1'b1; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            rd_req_valid = 1'b1; rd_req_addr = 30'(i);
            #1;
            chk($sformatf("r16 grant %0d", i), rd_req_ready, 1);
            @(negedge clk);
            #1;
            chk($sformatf("r16 issue %0d", i), app_en, 1);
        end
        @(negedge clk);
        wr_req_valid = 1'b1; wr_req_addr = 30'h300;
        #1;
        chk("r16 outstanding full", rd_outstanding, 16);
        chk("r16 17th rd_ready", rd_req_ready, 0);
        chk("r16 write ready", wr_req_ready, 1);
        @(negedge clk);
        wr_req_valid = 1'b0;
        #1;
        chk("r16 write app_en", app_en, 1);
        chk("r16 write app_cmd", app_cmd, 3'b000);
        @(negedge clk);
        app_rd_data = {64{8'h5A}}; app_rd_data_valid = 1'b1; app_rd_data_end = 1'b1;
        #1;
        chk("r16 still gated", rd_req_ready, 0);
        chk("r16 outstanding before ret", rd_outstanding, 16);
        @(negedge clk);
        app_rd_data_valid = 1'b0; app_rd_data_end = 1'b0;
        #1;
        chk("r16 rsp_valid", rd_rsp_valid, 1);
        chk("r16 rsp_data", rd_rsp_data, {64{8'h5A}});
        chk("r16 outstanding 15", rd_outstanding, 15);
        chk("r16 17th granted", rd_req_ready, 1);
        @(negedge clk);
        rd_req_valid = 1'b0;
        #1;
        chk("r16 rsp pulse ends", rd_rsp_valid, 0);
        chk("r16 17th cmd", app_cmd, 3'b001);
        chk("r16 17th app_en", app_en, 1);
        @(negedge clk);
        #1;
        chk("r16 outstanding back to 16", rd_outstanding, 16);

        // Accept and return in the same cycle; then underflow
        do_reset();
        @(negedge clk);
        init_calib_complete = 1'b1; app_rdy = 1'b1;
        @(negedge clk);
        rd_req_valid = 1'b1;
        #1;
        chk("ar grant1", rd_req_ready, 1);
        @(negedge clk);
        rd_req_valid = 1'b0;
        @(negedge clk);
        rd_req_valid = 1'b1;
        #1;
        chk("ar outstanding 1", rd_outstanding, 1);
        chk("ar grant2", rd_req_ready, 1);
        @(negedge clk);
        rd_req_valid = 1'b0;
        app_rd_data = {64{8'h77}}; app_rd_data_valid = 1'b1; app_rd_data_end = 1'b1;
        #1;
        chk("ar issue2 app_en", app_en, 1);
        @(negedge clk);
        app_rd_data_valid = 1'b0; app_rd_data_end = 1'b0;
        #1;
        chk("ar outstanding unchanged", rd_outstanding, 1);
        chk("ar rsp_valid", rd_rsp_valid, 1);
        chk("ar rsp_data", rd_rsp_data, {64{8'h77}});
        @(negedge clk);
        app_rd_data_valid = 1'b1; app_rd_data_end = 1'b1;
        #1;
        chk("uf err before", err_underflow, 0);
        @(negedge clk);
        app_rd_data = {64{8'h99}};
        #1;
        chk("uf outstanding 0", rd_outstanding, 0);
        chk("uf err still 0", err_underflow, 0);
        @(negedge clk);
        app_rd_data_valid = 1'b0; app_rd_data_end = 1'b0;
        #1;
        chk("uf err set", err_underflow, 1);
        chk("uf outstanding held 0", rd_outstanding, 0);
        chk("uf data forwarded", rd_rsp_data, {64{8'h99}});
        chk("uf rsp_valid", rd_rsp_valid, 1);
        repeat (3) @(negedge clk);
        #1;
        chk("uf err sticky", err_underflow, 1);
        do_reset();
        #1;
        chk("uf err cleared by rst", err_underflow, 0);

        // Reset while a write is stalled in WR_ISSUE with a read outstanding
        @(negedge clk);
        init_calib_complete = 1'b1; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        @(negedge clk);
        rd_req_valid = 1'b1;
        @(negedge clk);
        rd_req_valid = 1'b0;
        @(negedge clk);
        wr_req_valid = 1'b1; app_rdy = 1'b0; app_wdf_rdy = 1'b0;
        #1;
        chk("mr outstanding 1", rd_outstanding, 1);
        chk("mr wr_ready", wr_req_ready, 1);
        @(negedge clk);
        wr_req_valid = 1'b0;
        #1;
        chk("mr app_en before rst", app_en, 1);
        chk("mr wren before rst", app_wdf_wren, 1);
        rst = 1'b1;
        #1;
        chk("mr app_en after rst", app_en, 0);
        chk("mr wren after rst", app_wdf_wren, 0);
        chk("mr outstanding after rst", rd_outstanding, 0);
        init_calib_complete = 1'b0; wr_req_valid = 1'b1; rd_req_valid = 1'b1;
        app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("nocal wr_ready %0d", k), wr_req_ready, 0);
            chk($sformatf("nocal rd_ready %0d", k), rd_req_ready, 0);
            chk($sformatf("nocal app_en %0d", k), app_en, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
